lieat_exu_com_trap: RTL and testbench

- Commit-stage trap sequencer that sits directly upstream of the machine CSR register file.
- On a committing ECALL, EBREAK or MRET it sequences the CSR side effects.
  - Trap: a dual-port write of mepc and mcause in one cycle.
  - Both: a read of the target vector (mtvec for a trap, mepc for MRET) over the IFU CSR read port.
- It then holds a pipeline flush and a redirect request to the IFU until the redirect is accepted.
- Ordinary instructions pass through with no action.

---
 rtl/lieat_exu_com_trap.sv | 139 +++++++++++++
 tb/tb_lieat_exu_com_trap.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lieat_exu_com_trap.sv
// Commit-stage trap sequencer. On a committing ECALL/EBREAK it writes mepc and
// mcause, reads mtvec, and redirects fetch there. On a committing MRET it reads
// mepc and redirects fetch there. While a sequence runs it holds a pipeline
// flush and blocks new commits.
module lieat_exu_com_trap #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned CSR_IDX       = 12,
    parameter int unsigned MCAUSE_ECALL  = 11,
    parameter int unsigned MCAUSE_EBREAK = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               com_valid,
    output logic               com_ready,
    input  logic               com_ecall,
    input  logic               com_ebreak,
    input  logic               com_mret,
    input  logic [XLEN-1:0]    com_pc,
    output logic               trap_csr_ena,
    output logic               trap_csr_write,
    output logic [CSR_IDX-1:0] trap_csr_idx,
    output logic [XLEN-1:0]    trap_csr_wdata,
    output logic [CSR_IDX-1:0] trap_csr_idx2,
    output logic [XLEN-1:0]    trap_csr_wdata2,
    output logic               ifu_csr_ren,
    output logic [CSR_IDX-1:0] ifu_csr_idx,
    input  logic [XLEN-1:0]    ifu_csr_rdata,
    output logic               flush,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    input  logic               redirect_ready
);

    localparam logic [CSR_IDX-1:0] IdxMtvec   = CSR_IDX'(12'h305);
    localparam logic [CSR_IDX-1:0] IdxMepc    = CSR_IDX'(12'h341);
    localparam logic [CSR_IDX-1:0] IdxMcause  = CSR_IDX'(12'h342);
    localparam logic [XLEN-1:0]    CauseEcall  = XLEN'(MCAUSE_ECALL);
    localparam logic [XLEN-1:0]    CauseEbreak = XLEN'(MCAUSE_EBREAK);
    localparam logic [XLEN-1:0]    AlignMask   = ~XLEN'(3);

    typedef enum logic [1:0] {StIdle, StTrapWr, StRdVec, StRedir} state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   cause_q;
    logic [XLEN-1:0]   target_q;
    logic              mret_q;
    logic              flush_q;

    logic              is_trap;
    logic              accept;
    logic              handshake;
    logic [XLEN-1:0]   rdata_aligned;

    assign is_trap       = com_ecall | com_ebreak;
    assign accept        = com_valid & com_ready & (is_trap | com_mret);
    assign handshake     = redirect_valid & redirect_ready;
    // Vector targets are word aligned; low mode bits of mtvec are dropped.
    assign rdata_aligned = ifu_csr_rdata & AlignMask;

    // Sequencer state, latched commit info and the registered flush.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            cause_q  <= '0;
            target_q <= '0;
            mret_q   <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        pc_q    <= com_pc;
                        // ECALL wins over EBREAK, and either trap wins over MRET.
                        mret_q  <= ~is_trap;
                        cause_q <= com_ecall  ? CauseEcall  :
                                   com_ebreak ? CauseEbreak : '0;
                        flush_q <= 1'b1;
                        state_q <= is_trap ? StTrapWr : StRdVec;
                    end
                end
                StTrapWr: begin
                    state_q <= StRdVec;
                end
                StRdVec: begin
                    target_q <= rdata_aligned;
                    state_q  <= StRedir;
                end
                StRedir: begin
                    if (handshake) begin
                        flush_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Output decode from the current state; everything idles at zero.
    always_comb begin
        com_ready       = 1'b0;
        trap_csr_ena    = 1'b0;
        trap_csr_write  = 1'b0;
        trap_csr_idx    = '0;
        trap_csr_wdata  = '0;
        trap_csr_idx2   = '0;
        trap_csr_wdata2 = '0;
        ifu_csr_ren     = 1'b0;
        ifu_csr_idx     = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        flush           = flush_q;
        unique case (state_q)
            StIdle: begin
                com_ready = 1'b1;
            end
            StTrapWr: begin
                trap_csr_ena    = 1'b1;
                trap_csr_write  = 1'b1;
                trap_csr_idx    = IdxMepc;
                trap_csr_wdata  = pc_q;
                trap_csr_idx2   = IdxMcause;
                trap_csr_wdata2 = cause_q;
            end
            StRdVec: begin
                ifu_csr_ren = 1'b1;
                ifu_csr_idx = mret_q ? IdxMepc : IdxMtvec;
            end
            StRedir: begin
                redirect_valid = 1'b1;
                redirect_pc    = target_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lieat_exu_com_trap.sv
// Directed bench for the commit-stage trap sequencer. A tiny CSR model
// (mtvec/mepc) answers the combinational vector read and absorbs mepc writes.
module tb_lieat_exu_com_trap;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        clock;
    logic        reset;
    logic        com_valid;
    logic        com_ready;
    logic        com_ecall;
    logic        com_ebreak;
    logic        com_mret;
    logic [31:0] com_pc;
    logic        trap_csr_ena;
    logic        trap_csr_write;
    logic [11:0] trap_csr_idx;
    logic [31:0] trap_csr_wdata;
    logic [11:0] trap_csr_idx2;
    logic [31:0] trap_csr_wdata2;
    logic        ifu_csr_ren;
    logic [11:0] ifu_csr_idx;
    logic [31:0] ifu_csr_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    logic [31:0] mtvec_m;
    logic [31:0] mepc_m;

    int checks = 0;
    int errors = 0;

    lieat_exu_com_trap dut (
        .clock           (clock),
        .reset           (reset),
        .com_valid       (com_valid),
        .com_ready       (com_ready),
        .com_ecall       (com_ecall),
        .com_ebreak      (com_ebreak),
        .com_mret        (com_mret),
        .com_pc          (com_pc),
        .trap_csr_ena    (trap_csr_ena),
        .trap_csr_write  (trap_csr_write),
        .trap_csr_idx    (trap_csr_idx),
        .trap_csr_wdata  (trap_csr_wdata),
        .trap_csr_idx2   (trap_csr_idx2),
        .trap_csr_wdata2 (trap_csr_wdata2),
        .ifu_csr_ren     (ifu_csr_ren),
        .ifu_csr_idx     (ifu_csr_idx),
        .ifu_csr_rdata   (ifu_csr_rdata),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .redirect_ready  (redirect_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // CSR file model: combinational read, mepc write on the clock edge.
    always_comb begin
        ifu_csr_rdata = '0;
        if (ifu_csr_ren) begin
            if (ifu_csr_idx == 12'h305)      ifu_csr_rdata = mtvec_m;
            else if (ifu_csr_idx == 12'h341) ifu_csr_rdata = mepc_m;
        end
    end

    always @(posedge clock) begin
        if (trap_csr_ena && trap_csr_write && trap_csr_idx == 12'h341)
            mepc_m <= trap_csr_wdata;
    end

    typedef struct {
        logic        rst, v, ec, eb, mr, rr;
        logic [31:0] pc, mtvec;
    } in_t;

    typedef struct {
        logic        rdy, wr, ren, fl, rv;
        logic [11:0] idx, idx2, ridx;
        logic [31:0] wd, wd2, rpc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t tbl[$];

    function automatic in_t ii(input bit rst, input bit v, input bit ec, input bit eb,
                               input bit mr, input bit rr, input logic [31:0] pc,
                               input logic [31:0] mtv);
        in_t r;
        r.rst = rst; r.v = v; r.ec = ec; r.eb = eb; r.mr = mr; r.rr = rr;
        r.pc = pc; r.mtvec = mtv;
        return r;
    endfunction

    function automatic exp_t e_idle();
        exp_t e;
        e = '{default: '0};
        e.rdy = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_wr(input logic [31:0] pc, input logic [31:0] cause);
        exp_t e;
        e = '{default: '0};
        e.fl = 1'b1; e.wr = 1'b1;
        e.idx = 12'h341; e.wd = pc; e.idx2 = 12'h342; e.wd2 = cause;
        return e;
    endfunction

    function automatic exp_t e_rd(input logic [11:0] ridx);
        exp_t e;
        e = '{default: '0};
        e.fl = 1'b1; e.ren = 1'b1; e.ridx = ridx;
        return e;
    endfunction

    function automatic exp_t e_redir(input logic [31:0] pc);
        exp_t e;
        e = '{default: '0};
        e.fl = 1'b1; e.rv = 1'b1; e.rpc = pc;
        return e;
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t r;
        r.i = i;
        r.e = e;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input in_t i);
        reset          = i.rst;
        com_valid      = i.v;
        com_ecall      = i.ec;
        com_ebreak     = i.eb;
        com_mret       = i.mr;
        redirect_ready = i.rr;
        com_pc         = i.pc;
        mtvec_m        = i.mtvec;
    endtask

    initial begin
        int n;
        logic [31:0] tv;
        tv = 32'h80000100;
        // ECALL, no stall: accept at row 1
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_idle());
        add(ii(H, H, H, L, L, H, 32'h80000040, tv), e_idle());
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_wr(32'h80000040, 32'd11));
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_rd(12'h305));
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_redir(32'h80000100));
        // EBREAK with misaligned mtvec
        add(ii(H, H, L, H, L, H, 32'h1234,     32'h203), e_idle());
        add(ii(H, L, L, L, L, H, 32'h0,        32'h203), e_wr(32'h1234, 32'd3));
        add(ii(H, L, L, L, L, H, 32'h0,        32'h203), e_rd(12'h305));
        add(ii(H, L, L, L, L, H, 32'h0,        32'h203), e_redir(32'h200));
        // ECALL+MRET together takes the trap; then 5 cycles of backpressure
        add(ii(H, H, H, L, H, H, 32'h80000044, tv), e_idle());
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_wr(32'h80000044, 32'd11));
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_rd(12'h305));
        for (int k = 0; k < 5; k++)
            add(ii(H, H, H, L, L, L, 32'hdead0000, tv), e_redir(32'h80000100));
        add(ii(H, H, H, L, L, H, 32'hdead0000, tv), e_redir(32'h80000100));
        // MRET reads the mepc written above
        add(ii(H, H, L, L, H, H, 32'h0,        tv), e_idle());
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_rd(12'h341));
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_redir(32'h80000044));
        // No-op commit
        add(ii(H, H, L, L, L, H, 32'h123,      tv), e_idle());
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_idle());
        // Reset while in RD_VEC aborts the sequence
        add(ii(H, H, H, L, L, H, 32'h80000040, tv), e_idle());
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_wr(32'h80000040, 32'd11));
        add(ii(L, L, L, L, L, H, 32'h0,        tv), e_rd(12'h305));
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_idle());
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_idle());
        add(ii(H, L, L, L, L, H, 32'h0,        tv), e_idle());

        mepc_m = '0;
        drive(ii(L, L, L, L, L, L, 32'h0, tv));
        tick();
        tick();

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].i);
            @(negedge clock);
            chk($sformatf("r%0d_com_ready", r), 32'(com_ready),       32'(tbl[r].e.rdy));
            chk($sformatf("r%0d_csr_ena", r),   32'(trap_csr_ena),    32'(tbl[r].e.wr));
            chk($sformatf("r%0d_csr_write", r), 32'(trap_csr_write),  32'(tbl[r].e.wr));
            chk($sformatf("r%0d_csr_idx", r),   32'(trap_csr_idx),    32'(tbl[r].e.idx));
            chk($sformatf("r%0d_csr_wdata", r), trap_csr_wdata,       tbl[r].e.wd);
            chk($sformatf("r%0d_csr_idx2", r),  32'(trap_csr_idx2),   32'(tbl[r].e.idx2));
            chk($sformatf("r%0d_csr_wdata2", r), trap_csr_wdata2,     tbl[r].e.wd2);
            chk($sformatf("r%0d_ifu_ren", r),   32'(ifu_csr_ren),     32'(tbl[r].e.ren));
            chk($sformatf("r%0d_ifu_idx", r),   32'(ifu_csr_idx),     32'(tbl[r].e.ridx));
            chk($sformatf("r%0d_flush", r),     32'(flush),           32'(tbl[r].e.fl));
            chk($sformatf("r%0d_redir_valid", r), 32'(redirect_valid), 32'(tbl[r].e.rv));
            chk($sformatf("r%0d_redir_pc", r),  redirect_pc,          tbl[r].e.rpc);
            tick();
        end

        // Trap latency measured with a bounded wait, then a held redirect
        drive(ii(H, H, H, L, L, L, 32'h100, 32'h300));
        tick();
        com_valid = 1'b0;
        com_ecall = 1'b0;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (redirect_valid) begin
                n = c;
                break;
            end
            tick();
        end
        chk("lat_redirect_cycles", 32'(n), 32'd3);
        chk("lat_redirect_pc", redirect_pc, 32'h300);
        tick();
        @(negedge clock);
        chk("hold_flush", 32'(flush), 32'd1);
        chk("hold_redir_valid", 32'(redirect_valid), 32'd1);
        chk("hold_com_ready", 32'(com_ready), 32'd0);
        redirect_ready = 1'b1;
        tick();
        @(negedge clock);
        chk("post_hs_flush", 32'(flush), 32'd0);
        chk("post_hs_com_ready", 32'(com_ready), 32'd1);
        chk("post_hs_redir_valid", 32'(redirect_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
